trim_dac_sched: RTL and testbench
=================================

Name: trim_dac_sched

Overview:
Scheduler and write-port arbiter in front of the trim DAC controller. It merges LUT writes from the UART decoder and the auto-calibration engine onto the single 7-bit trim LUT write port. It tracks whether DAC codes have changed, batches bursts of writes behind a holdoff timer, and issues one load_dacs strobe. It never strobes while the DAC serial sequence is still running. Runs in the 40 MHz domain between uart_decoder/cal engine and trim_dac_ctrl.

Parameters:
HOLDOFF_CYCLES, 4000, clk40 cycles of write silence before a load is issued (100 us)
BUSY_CYCLES, 640, clk40 cycles one full 3-pass DAC update occupies, margin included
CNT_W, 16, width of holdoff/busy counters; must hold max(HOLDOFF_CYCLES, BUSY_CYCLES)

Ports:
clk40  in  1  system clock, 40 MHz
rst  in  1  synchronous reset, active-high
uart_din  in  7  UART LUT data
uart_addr  in  5  UART LUT address
uart_we  in  1  UART write strobe, single cycle, cannot be stalled
cal_din  in  7  calibration LUT data
cal_addr  in  5  calibration LUT address
cal_req  in  1  calibration write request; held with data stable until cal_gnt
cal_gnt  out  1  one-cycle grant; coincides with the cal write on lut_we
force_load  in  1  single-cycle request for an immediate DAC load
lut_in  out  7  to trim_dac_ctrl lut_in
lut_addr  out  5  to trim_dac_ctrl lut_addr
lut_we  out  1  to trim_dac_ctrl lut_we
load_dacs  out  1  to trim_dac_ctrl load_dacs, single-cycle pulse
busy  out  1  DAC update in progress
pending  out  1  LUT changed since the last load was issued

Behaviour:
- Clocking and reset: one clock (clk40). Reset is synchronous and active-high (rst). Reset forces all outputs to 0, the FSM to IDLE, and clears dirty and all counters. Reset wins over every other input, including mid-HOLDOFF and mid-BUSY.
- Write path is registered, 1-cycle latency.
  - uart_we at cycle N: lut_we/lut_addr/lut_in carry the UART data at N+1.
  - UART has absolute priority.
  - The cal request is granted only if uart_we=0, cal_gnt=0 and state is not FIRE/BUSY. The cal write then appears at N+1 with cal_gnt=1 that same cycle.
  - Because no grant is given while cal_gnt=1, back-to-back cal grants are at least 2 cycles apart. This prevents a double write from a held request.
  - UART writes during FIRE/BUSY are still passed through (they cannot be stalled). They set dirty.
- Dirty rule:
  - A lut_we with lut_addr <= 17 (9 DACs x 2 half-words) sets dirty. Addresses 18-31 are written but do not set dirty.
  - dirty is cleared in the FIRE cycle, unless a dirty write lands in that same cycle; the write wins.
  - pending = dirty.
- FSM:
  - IDLE: a dirty write, or dirty=1 -> HOLDOFF; holdoff counter loads HOLDOFF_CYCLES-1. force_load=1 -> FIRE.
  - HOLDOFF: each dirty write reloads the counter. The counter decrements otherwise. At 0 with no write that cycle -> FIRE. force_load=1 -> FIRE.
  - FIRE: load_dacs=1 for exactly this cycle; dirty cleared; busy counter loads BUSY_CYCLES-1 -> BUSY.
  - BUSY: counter decrements. At 0 -> HOLDOFF if dirty, else IDLE. force_load is ignored in BUSY.
- Timing:
  - Net effect: load_dacs is asserted HOLDOFF_CYCLES+1 cycles after the last dirty lut_we cycle.
  - busy=1 in FIRE and BUSY: BUSY_CYCLES+1 cycles total, starting the cycle load_dacs is high.
  - The minimum spacing between load_dacs pulses is BUSY_CYCLES+2.
- Simultaneous events: force_load together with uart_we in IDLE: the write is forwarded and FIRE is entered next cycle. Dirty is cleared in FIRE only if no new dirty write lands then.

Optional Feature:
TRIM_LOAD_CNT_EN.
- Defined: adds output port load_count [15:0]. It resets to 0 and increments in each FIRE cycle, wrapping 0xFFFF->0x0000. Readable by uart_decoder.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
(Bench parameters: HOLDOFF_CYCLES=8, BUSY_CYCLES=20.)
- Single uart_we to addr 3, data 0x55 at cycle 10 -> lut_we/addr 3/data 0x55 at 11; pending=1; load_dacs pulse at 20; busy 20..40; pending=0 at 21.
- uart_we and cal_req(addr 5, 0x12) both at cycle 10 -> UART write at 11; cal write and cal_gnt at 12; one load_dacs, at 21.
- UART writes every 4 cycles for 40 cycles -> no load_dacs during the burst; exactly one pulse 9 cycles after the last lut_we.
- Write addr 20 only -> lut_we forwarded, pending stays 0, no load_dacs; then force_load -> load_dacs next cycle.
- UART write during BUSY -> forwarded immediately; cal_req stalled until BUSY ends. A second load_dacs follows holdoff expiry, not earlier than 22 cycles after the first.
- rst asserted mid-BUSY -> next cycle busy=0, pending=0, load_dacs=0; with TRIM_LOAD_CNT_EN, load_count=0.

Source files
------------

// File: rtl/trim_dac_sched.sv
// trim_dac_sched: merges UART/cal LUT writes and batches DAC loads behind a holdoff timer.
// Define TRIM_LOAD_CNT_EN to add the load_count output (FIRE events, wraps at 16 bits).
module trim_dac_sched #(
  parameter int HOLDOFF_CYCLES = 4000,
  parameter int BUSY_CYCLES    = 640,
  parameter int CNT_W          = 16
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic [6:0]  uart_din,
  input  logic [4:0]  uart_addr,
  input  logic        uart_we,
  input  logic [6:0]  cal_din,
  input  logic [4:0]  cal_addr,
  input  logic        cal_req,
  output logic        cal_gnt,
  input  logic        force_load,
  output logic [6:0]  lut_in,
  output logic [4:0]  lut_addr,
  output logic        lut_we,
  output logic        load_dacs,
  output logic        busy,
`ifdef TRIM_LOAD_CNT_EN
  output logic [15:0] load_count,
`endif
  output logic        pending
);
  typedef enum logic [1:0] {IDLE, HOLDOFF, FIRE, BUSY} state_t;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUSY_LD = CNT_W'(BUSY_CYCLES - 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dirty;
  logic             w_cal_ok;
  logic             w_dirty_wr;
  logic             w_dirty_any;
  logic             w_fire;
  // No grant while cal_gnt is high, so a held request cannot write twice.
  assign w_cal_ok    = cal_req && !uart_we && !cal_gnt && r_state != FIRE && r_state != BUSY;
  assign w_dirty_wr  = lut_we && lut_addr <= 5'd17;
  assign w_dirty_any = r_dirty || w_dirty_wr;
  assign w_fire      = (r_state == IDLE || r_state == HOLDOFF) &&
                       (force_load || (r_state == HOLDOFF && r_cnt == '0 && !w_dirty_wr));
  assign pending     = r_dirty;
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dirty   <= 1'b0;
      lut_we    <= 1'b0;
      lut_addr  <= '0;
      lut_in    <= '0;
      cal_gnt   <= 1'b0;
      load_dacs <= 1'b0;
      busy      <= 1'b0;
    end else begin
      lut_we    <= uart_we || w_cal_ok;
      lut_addr  <= uart_we ? uart_addr : cal_addr;
      lut_in    <= uart_we ? uart_din : cal_din;
      cal_gnt   <= w_cal_ok;
      load_dacs <= w_fire;
      r_dirty   <= w_dirty_any;
      if (w_fire) begin
        r_state <= FIRE;
        busy    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= w_dirty_any ? HOLDOFF : IDLE;
            r_cnt   <= HOLD_LD;
          end
          HOLDOFF: r_cnt <= w_dirty_wr ? HOLD_LD : r_cnt - 1'b1;
          FIRE: begin
            r_dirty <= w_dirty_wr;
            r_state <= BUSY;
            r_cnt   <= BUSY_LD;
          end
          default: begin
            r_cnt   <= r_cnt == '0 ? HOLD_LD : r_cnt - 1'b1;
            busy    <= r_cnt != '0;
            r_state <= r_cnt != '0 ? BUSY : (w_dirty_any ? HOLDOFF : IDLE);
          end
        endcase
      end
    end
  end
`ifdef TRIM_LOAD_CNT_EN
  always_ff @(posedge clk40) begin
    if (rst) load_count <= '0;
    else if (r_state == FIRE) load_count <= load_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_trim_dac_sched.sv
// tb_trim_dac_sched: scoreboard bench for trim_dac_sched with HOLDOFF_CYCLES=8, BUSY_CYCLES=20.
module tb_trim_dac_sched;
  logic       clk40 = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] uart_din = '0;
  logic [4:0] uart_addr = '0;
  logic       uart_we = 1'b0;
  logic [6:0] cal_din = '0;
  logic [4:0] cal_addr = '0;
  logic       cal_req = 1'b0;
  logic       cal_gnt;
  logic       force_load = 1'b0;
  logic [6:0] lut_in;
  logic [4:0] lut_addr;
  logic       lut_we;
  logic       load_dacs;
  logic       busy;
  logic       pending;
`ifdef TRIM_LOAD_CNT_EN
  logic [15:0] load_count;
`endif
  trim_dac_sched #(.HOLDOFF_CYCLES(8), .BUSY_CYCLES(20), .CNT_W(16)) dut (
    .clk40(clk40), .rst(rst), .uart_din(uart_din), .uart_addr(uart_addr), .uart_we(uart_we),
    .cal_din(cal_din), .cal_addr(cal_addr), .cal_req(cal_req), .cal_gnt(cal_gnt),
    .force_load(force_load), .lut_in(lut_in), .lut_addr(lut_addr), .lut_we(lut_we),
    .load_dacs(load_dacs), .busy(busy),
`ifdef TRIM_LOAD_CNT_EN
    .load_count(load_count),
`endif
    .pending(pending)
  );
  typedef struct {int c; logic [4:0] a; logic [6:0] d; logic g;} wr_t;
  wr_t wq[$];
  int  lq[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  t, u, f;
  always #5 clk40 = ~clk40;
  always @(posedge clk40) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk40);
    #1;
  endtask
  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask
  task automatic uwr(input logic [4:0] a, input logic [6:0] d);
    uart_we = 1'b1;
    uart_addr = a;
    uart_din = d;
    wq.push_back('{cyc + 1, a, d, 1'b0});
    step();
    uart_we = 1'b0;
  endtask
  always @(negedge clk40) begin
    if (lut_we) begin
      if (wq.size() == 0) chk("wr_unexpected", lut_we, 1'b0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr", lut_addr, e.a);
        chk("wr_data", lut_in, e.d);
        chk("wr_gnt", cal_gnt, e.g);
      end
    end
    if (load_dacs) begin
      if (lq.size() == 0) chk("load_unexpected", load_dacs, 1'b0);
      else chk("load_cycle", cyc, lq.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) step();
    chk("rst_lut_we", lut_we, 0);
    chk("rst_load", load_dacs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_gnt", cal_gnt, 0);
`ifdef TRIM_LOAD_CNT_EN
    chk("rst_count", load_count, 0);
`endif
    rst = 1'b0;
    step();
    // single dirty write
    t = cyc;
    lq.push_back(t + 10);
    uwr(5'd3, 7'h55);
    step();
    chk("t1_pending", pending, 1);
    wait_until(t + 10);
    chk("t1_busy_start", busy, 1);
    wait_until(t + 11);
    chk("t1_pending_clr", pending, 0);
`ifdef TRIM_LOAD_CNT_EN
    chk("t1_count", load_count, 1);
`endif
    wait_until(t + 30);
    chk("t1_busy_end", busy, 1);
    step();
    chk("t1_busy_off", busy, 0);
    wait_until(t + 40);
    // UART and cal collide
    t = cyc;
    uart_we = 1'b1; uart_addr = 5'd7; uart_din = 7'h2A;
    cal_req = 1'b1; cal_addr = 5'd5; cal_din = 7'h12;
    wq.push_back('{t + 1, 5'd7, 7'h2A, 1'b0});
    wq.push_back('{t + 2, 5'd5, 7'h12, 1'b1});
    lq.push_back(t + 11);
    step();
    uart_we = 1'b0;
    step();
    chk("t2_gnt", cal_gnt, 1);
    cal_req = 1'b0;
    wait_until(t + 40);
    // burst every 4 cycles
    t = cyc;
    lq.push_back(t + 46);
    for (int i = 0; i < 10; i++) begin
      uwr(5'(i), 7'(i * 3));
      repeat (3) step();
    end
    wait_until(t + 70);
    // non-dirty write then force_load
    t = cyc;
    uwr(5'd20, 7'h7F);
    step();
    step();
    chk("t4_pending", pending, 0);
    repeat (12) step();
    u = cyc;
    force_load = 1'b1;
    lq.push_back(u + 1);
    step();
    force_load = 1'b0;
    chk("t4_busy", busy, 1);
    wait_until(u + 30);
    chk("t4_idle", busy, 0);
    // UART during BUSY, cal stalled, force_load ignored in BUSY
    t = cyc;
    f = t + 10;
    lq.push_back(f);
    uwr(5'd1, 7'h11);
    wait_until(f + 3);
    cal_req = 1'b1; cal_addr = 5'd9; cal_din = 7'h44;
    uwr(5'd2, 7'h33);
    wq.push_back('{f + 22, 5'd9, 7'h44, 1'b1});
    lq.push_back(f + 31);
    force_load = 1'b1;
    step();
    force_load = 1'b0;
    for (int k = 0; k < 40 && !cal_gnt; k++) step();
    chk("t5_gnt", cal_gnt, 1);
    chk("t5_gnt_cycle", cyc, f + 22);
    cal_req = 1'b0;
    chk("t5_busy_gap", busy, 0);
    wait_until(f + 31);
    chk("t5_busy2", busy, 1);
    // reset mid-BUSY with a dirty write outstanding
    wait_until(f + 33);
    uwr(5'd4, 7'h44);
    step();
    chk("t6_pending", pending, 1);
    rst = 1'b1;
    step();
    chk("t6_busy", busy, 0);
    chk("t6_pending_rst", pending, 0);
    chk("t6_load", load_dacs, 0);
    chk("t6_lut_we", lut_we, 0);
`ifdef TRIM_LOAD_CNT_EN
    chk("t6_count", load_count, 0);
`endif
    rst = 1'b0;
    repeat (30) step();
    chk("wq_left", wq.size(), 0);
    chk("lq_left", lq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
